// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write sequencer: sequencer state encoding,
// address width and the R/W bit value for a write transfer.
package i2c_pkg;

    localparam int   ADDR_W    = 7;
    localparam logic I2C_WRITE = 1'b0;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_EN    = 4'd1,
        S_ADDR  = 4'd2,
        S_WAIT  = 4'd3,
        S_CLR   = 4'd4,
        S_FETCH = 4'd5,
        S_WR    = 4'd6,
        S_DWAIT = 4'd7,
        S_STOP  = 4'd8,
        S_DONE  = 4'd9,
        S_ABORT = 4'd10
    } seq_state_t;

    // States that wait on the master and are therefore guarded by the watchdog.
    function automatic logic is_timed(seq_state_t s);
        return (s == S_EN) || (s == S_ADDR) || (s == S_WAIT) ||
               (s == S_DWAIT) || (s == S_STOP);
    endfunction

endpackage

// File: rtl/i2c_seq_timeout.sv
// Watchdog for the write sequencer. The count restarts whenever the
// sequencer changes state and advances only while enable is high. The
// cycle carrying clear counts as the first cycle of the new state, so
// expire rises in the TIMEOUT_CYC-th cycle spent in a guarded state.
module i2c_seq_timeout #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Count cycles spent in a guarded state; a clear loads the value the
    // next cycle will carry.
    // NOTE: reset is asynchronous; the sensitivity list must name the reset
    // edge or synthesis builds a synchronous reset instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= enable ? CNT_W'(1) : '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/i2c_write_sequencer.sv
// Sequences the I2C write master through START, address byte, cmd_len
// payload bytes pulled from a valid/ready stream, and STOP. A watchdog
// aborts the transfer if the master stalls in any waiting state.
module i2c_write_sequencer
    import i2c_pkg::*;
#(
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [7:0]        byte_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              m_ready,
    input  logic              m_hold,
    input  logic              m_tx_done,
    output logic              m_i2c_en,
    output logic              m_start,
    output logic              m_wr_en,
    output logic              m_stop,
    output logic              m_tx_clear,
    output logic [7:0]        m_tx_data
);

    seq_state_t       state;
    seq_state_t       prev_state;
    logic [LEN_W-1:0] rem_cnt;
    logic             tmo_clear;
    logic             tmo_enable;
    logic             tmo_expire;

    // Any state change restarts the watchdog; only master-wait states count.
    assign tmo_clear  = (state != prev_state);
    assign tmo_enable = is_timed(state);

    i2c_seq_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expire (tmo_expire)
    );

    // Transaction FSM with registered master controls and status outputs.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking '=' would leak new values into later lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            prev_state <= S_IDLE;
            rem_cnt    <= '0;
            cmd_ready  <= 1'b0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            m_i2c_en   <= 1'b0;
            m_start    <= 1'b0;
            m_wr_en    <= 1'b0;
            m_stop     <= 1'b0;
            m_tx_clear <= 1'b0;
            m_tx_data  <= '0;
        end else begin
            prev_state <= state;
            // Single-cycle pulses fall back low unless a state re-arms them.
            done       <= 1'b0;
            err        <= 1'b0;
            m_wr_en    <= 1'b0;
            m_tx_clear <= 1'b0;

            if (tmo_expire) begin
                // Abort: flush any pending byte-complete flag first so the
                // master will honour the following stop request.
                err        <= 1'b1;
                m_i2c_en   <= 1'b0;
                m_start    <= 1'b0;
                m_stop     <= 1'b0;
                m_tx_clear <= 1'b1;
                state      <= S_ABORT;
            end else begin
                case (state)
                    S_IDLE: begin
                        cmd_ready <= 1'b1;
                        if (cmd_ready && cmd_valid && m_ready) begin
                            m_tx_data <= {cmd_addr, I2C_WRITE};
                            rem_cnt   <= cmd_len;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            m_i2c_en  <= 1'b1;
                            state     <= S_EN;
                        end
                    end
                    S_EN: begin
                        // Enable must drop once the master holds, otherwise it
                        // re-enters HOLD after the STOP.
                        if (m_hold) begin
                            m_i2c_en <= 1'b0;
                            m_start  <= 1'b1;
                            state    <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (!m_hold) begin
                            m_start <= 1'b0;
                            state   <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (m_tx_done) begin
                            m_tx_clear <= 1'b1;
                            state      <= S_CLR;
                        end
                    end
                    S_CLR: begin
                        // The flag clears at the end of this cycle, so the next
                        // request reaches the master with m_tx_done already low.
                        if (rem_cnt == '0) begin
                            m_stop <= 1'b1;
                            state  <= S_STOP;
                        end else begin
                            byte_ready <= 1'b1;
                            state      <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        // Unbounded wait: the master stretches SCL low meanwhile.
                        if (byte_valid) begin
                            m_tx_data  <= byte_data;
                            rem_cnt    <= rem_cnt - LEN_W'(1);
                            byte_ready <= 1'b0;
                            m_wr_en    <= 1'b1;
                            state      <= S_WR;
                        end
                    end
                    S_WR: begin
                        state <= S_DWAIT;
                    end
                    S_DWAIT: begin
                        if (!m_hold) begin
                            state <= S_WAIT;
                        end
                    end
                    S_STOP: begin
                        if (m_ready) begin
                            m_stop <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else if (!m_hold) begin
                            m_stop <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                    S_ABORT: begin
                        // First cycle carries only the tx_clear pulse.
                        if (!m_tx_clear) begin
                            if (m_ready) begin
                                m_stop    <= 1'b0;
                                busy      <= 1'b0;
                                cmd_ready <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                m_stop <= m_hold;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer. A behavioural I2C master model,
// a payload byte source and a command driver all run on the falling edge;
// the DUT samples them on the rising edge.
`timescale 1ns/1ps
module tb_i2c_write_sequencer;

    localparam int LEN_W       = 4;
    localparam int TIMEOUT_CYC = 20000;
    localparam int EN_CYC      = 3;
    localparam int XFER_CYC    = 20;
    localparam int STOP_CYC    = 6;

    typedef struct {
        logic [6:0]       addr;
        logic [LEN_W-1:0] len;
    } cmd_t;

    typedef enum {M_IDLE, M_EN, M_HOLD, M_XFER, M_STOP} mst_t;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             cmd_valid  = 1'b0;
    logic [6:0]       cmd_addr   = '0;
    logic [LEN_W-1:0] cmd_len    = '0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data  = '0;
    logic             m_ready    = 1'b1;
    logic             m_hold     = 1'b0;
    logic             m_tx_done  = 1'b0;
    logic             cmd_ready, byte_ready, busy, done, err;
    logic             m_i2c_en, m_start, m_wr_en, m_stop, m_tx_clear;
    logic [7:0]       m_tx_data;
    logic [17:0]      out_vec;

    assign out_vec = {cmd_ready, byte_ready, busy, done, err, m_i2c_en, m_start,
                      m_wr_en, m_stop, m_tx_clear, m_tx_data};

    i2c_write_sequencer #(
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .m_ready    (m_ready),
        .m_hold     (m_hold),
        .m_tx_done  (m_tx_done),
        .m_i2c_en   (m_i2c_en),
        .m_start    (m_start),
        .m_wr_en    (m_wr_en),
        .m_stop     (m_stop),
        .m_tx_clear (m_tx_clear),
        .m_tx_data  (m_tx_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Stimulus queues and model state
    cmd_t       cmd_q[$];
    logic [7:0] byte_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];
    mst_t       mst = M_IDLE;
    int         xcnt = 0;
    logic [7:0] shreg = '0;
    bit         started = 0;
    bit         stall = 0;
    bit         src_en = 1;
    bit         byte_pend = 0;
    bit         busy_q = 0;
    bit         ready_q = 1;
    bit         clr_prev = 0;
    bit         ok;

    // Statistics, cleared per test
    int done_cnt, err_cnt, both_cnt, hs_cnt, clr_cnt, clr_wide, start_cnt, stop_cnt;
    int viol, reenter, accept_cnt, acc2_done, err_cyc, drop_cyc;
    bit br_seen, stop_seen, en_between, acc2_ready;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, sent_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (i < sent_q.size()) ? {24'd0, sent_q[i]} : 32'hFFFF_FFFF, exp_q[i]);
        end
    endtask

    task automatic clear_stats();
        done_cnt = 0; err_cnt = 0; both_cnt = 0; hs_cnt = 0; clr_cnt = 0; clr_wide = 0;
        start_cnt = 0; stop_cnt = 0; viol = 0; reenter = 0; accept_cnt = 0;
        acc2_done = -1; err_cyc = -1; drop_cyc = -1;
        br_seen = 0; stop_seen = 0; en_between = 0; acc2_ready = 0;
        sent_q.delete();
        exp_q.delete();
    endtask

    // Wait until n_acc commands were accepted and everything is idle again.
    task automatic wait_quiet(input string tag, input int n_acc, input int budget);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (accept_cnt >= n_acc) && !busy && cmd_ready && (mst == M_IDLE) &&
                 (cmd_q.size() == 0);
        end
        check(tag, ok, 1);
    endtask

    // Monitor, master model, byte source and command driver, in that order.
    always @(negedge clk) begin
        if (rst) begin
            mst = M_IDLE; m_ready = 1; m_hold = 0; m_tx_done = 0; started = 0;
            byte_valid = 0; byte_data = '0; byte_pend = 0;
            cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
            cmd_q.delete(); byte_q.delete();
            busy_q = 0; ready_q = 1; clr_prev = 0;
        end else begin
            if (done) done_cnt++;
            if (err) begin
                if (err_cnt == 0) err_cyc = cyc;
                err_cnt++;
            end
            if (done && err) both_cnt++;
            if (m_tx_clear) begin
                clr_cnt++;
                if (clr_prev) clr_wide++;
            end
            clr_prev = m_tx_clear;
            if (byte_ready) br_seen = 1;
            if (m_stop) stop_seen = 1;
            if (busy && !busy_q) begin
                accept_cnt++;
                if (accept_cnt == 2) begin
                    acc2_done  = done_cnt;
                    acc2_ready = ready_q;
                end
                if (cmd_q.size() != 0) void'(cmd_q.pop_front());
            end
            if (done_cnt >= 1 && accept_cnt < 2 && m_i2c_en) en_between = 1;

            // Behavioural master
            if (m_tx_clear) m_tx_done = 0;
            case (mst)
                M_IDLE: begin
                    m_ready = 1;
                    if (m_i2c_en) begin
                        m_ready = 0; xcnt = EN_CYC; mst = M_EN;
                    end
                end
                M_EN: begin
                    xcnt--;
                    if (xcnt == 0) begin
                        m_hold = 1; mst = M_HOLD;
                    end
                end
                M_HOLD: begin
                    if (!started) begin
                        if (m_start) begin
                            started = 1; start_cnt++; drop_cyc = cyc;
                            m_hold = 0; shreg = m_tx_data; xcnt = XFER_CYC; mst = M_XFER;
                        end
                    end else if (m_wr_en || m_stop) begin
                        if (m_tx_done) viol++;
                        else if (m_wr_en) begin
                            m_hold = 0; shreg = m_tx_data; xcnt = XFER_CYC; mst = M_XFER;
                        end else begin
                            m_hold = 0; xcnt = STOP_CYC; mst = M_STOP;
                        end
                    end
                end
                M_XFER: begin
                    xcnt--;
                    if (xcnt == 0) begin
                        sent_q.push_back(shreg);
                        m_hold = 1;
                        if (!stall) m_tx_done = 1;
                        mst = M_HOLD;
                    end
                end
                M_STOP: begin
                    xcnt--;
                    if (xcnt == 0) begin
                        stop_cnt++; started = 0;
                        if (m_i2c_en) begin
                            reenter++; m_hold = 1; mst = M_HOLD;
                        end else begin
                            m_ready = 1; mst = M_IDLE;
                        end
                    end
                end
                default: mst = M_IDLE;
            endcase

            // Byte source: a handshake seen here completes at the next rising edge.
            if (byte_pend) begin
                void'(byte_q.pop_front());
                hs_cnt++;
                byte_pend = 0;
            end
            byte_valid = src_en && (byte_q.size() != 0);
            byte_data  = byte_valid ? byte_q[0] : 8'h00;
            if (byte_valid && byte_ready) byte_pend = 1;

            // Command driver
            cmd_valid = (cmd_q.size() != 0);
            cmd_addr  = cmd_valid ? cmd_q[0].addr : '0;
            cmd_len   = cmd_valid ? cmd_q[0].len  : '0;

            busy_q  = busy;
            ready_q = m_ready;
        end
    end

    initial begin
        clear_stats();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_outputs", out_vec, 0);
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);

        // Two-byte write to 0x3C
        clear_stats();
        byte_q.push_back(8'hA5); byte_q.push_back(8'h0F);
        cmd_q.push_back('{addr: 7'h3C, len: 4'd2});
        wait_quiet("t1_end", 1, 2000);
        exp_q.push_back(8'h78); exp_q.push_back(8'hA5); exp_q.push_back(8'h0F);
        check_bytes("t1");
        check("t1_starts", start_cnt, 1);
        check("t1_stops", stop_cnt, 1);
        check("t1_handshakes", hs_cnt, 2);
        check("t1_tx_clears", clr_cnt, 3);
        check("t1_clear_width", clr_wide, 0);
        check("t1_done", done_cnt, 1);
        check("t1_err", err_cnt, 0);
        check("t1_protocol", viol, 0);

        // Address-only transaction
        clear_stats();
        cmd_q.push_back('{addr: 7'h50, len: 4'd0});
        wait_quiet("t2_end", 1, 2000);
        exp_q.push_back(8'hA0);
        check_bytes("t2");
        check("t2_done", done_cnt, 1);
        check("t2_byte_ready_seen", br_seen, 0);
        check("t2_tx_clears", clr_cnt, 1);
        check("t2_stops", stop_cnt, 1);

        // Payload withheld for 30000 cycles after the address byte
        clear_stats();
        src_en = 0;
        byte_q.push_back(8'h5A);
        cmd_q.push_back('{addr: 7'h21, len: 4'd1});
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (sent_q.size() == 1) && byte_ready;
        end
        check("t3_reach_fetch", ok, 1);
        repeat (30000) @(negedge clk);
        #1;
        check("t3_no_err", err_cnt, 0);
        check("t3_scl_held", m_hold, 1);
        check("t3_still_busy", busy, 1);
        check("t3_byte_ready", byte_ready, 1);
        src_en = 1;
        wait_quiet("t3_end", 1, 2000);
        exp_q.push_back(8'h42); exp_q.push_back(8'h5A);
        check_bytes("t3");
        check("t3_done", done_cnt, 1);
        check("t3_err_after", err_cnt, 0);

        // Master never reports byte completion -> watchdog abort
        clear_stats();
        stall = 1;
        byte_q.push_back(8'h77);
        cmd_q.push_back('{addr: 7'h2A, len: 4'd1});
        ok = 0;
        for (int i = 0; i < TIMEOUT_CYC + 1000 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (err_cnt != 0);
        end
        check("t4_err_seen", ok, 1);
        check("t4_err_latency", err_cyc - drop_cyc, TIMEOUT_CYC + 1);
        wait_quiet("t4_end", 1, 2000);
        check("t4_err_count", err_cnt, 1);
        check("t4_no_done", done_cnt, 0);
        check("t4_stop_driven", stop_seen, 1);
        check("t4_master_stopped", stop_cnt, 1);
        check("t4_byte_ready_seen", br_seen, 0);
        check("t4_done_err_overlap", both_cnt, 0);
        stall = 0;
        byte_q.delete();

        // Back-to-back commands with cmd_valid held high
        clear_stats();
        byte_q.push_back(8'h22); byte_q.push_back(8'h33);
        cmd_q.push_back('{addr: 7'h11, len: 4'd1});
        cmd_q.push_back('{addr: 7'h12, len: 4'd1});
        wait_quiet("t5_end", 2, 4000);
        check("t5_accepts", accept_cnt, 2);
        check("t5_done", done_cnt, 2);
        check("t5_second_after_done", acc2_done, 1);
        check("t5_second_master_ready", acc2_ready, 1);
        check("t5_en_low_between", en_between, 0);
        check("t5_reenter_hold", reenter, 0);
        exp_q.push_back(8'h22); exp_q.push_back(8'h22);
        exp_q.push_back(8'h24); exp_q.push_back(8'h33);
        check_bytes("t5");

        // Reset during the second data byte, then a clean transaction
        clear_stats();
        byte_q.push_back(8'h01); byte_q.push_back(8'h02);
        cmd_q.push_back('{addr: 7'h33, len: 4'd2});
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (mst == M_XFER) && (sent_q.size() == 2);
        end
        check("t6_reach_byte2", ok, 1);
        rst = 1;
        #1;
        check("t6_rst_outputs", out_vec, 0);
        repeat (3) @(negedge clk);
        #1;
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        check("t6_cmd_ready", cmd_ready, 1);
        clear_stats();
        byte_q.push_back(8'h99);
        cmd_q.push_back('{addr: 7'h44, len: 4'd1});
        wait_quiet("t6_end", 1, 2000);
        exp_q.push_back(8'h88); exp_q.push_back(8'h99);
        check_bytes("t6");
        check("t6_done", done_cnt, 1);
        check("t6_err", err_cnt, 0);
        check("t6_protocol", viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
